// File: rtl/wr_ptr_full_ctrl_pkg.sv
// Shared FIFO helpers: depth derivation and Gray/binary pointer conversions,
// reused by both the write-side and read-side pointer controllers.
package wr_ptr_full_ctrl_pkg;

    localparam int PTR_FN_W = 32;

    typedef logic [PTR_FN_W-1:0] ptr_word_t;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic ptr_word_t bin_to_gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray_to_bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < PTR_FN_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_ptr_full_ctrl_gray2bin.sv
// Parameterised Gray-to-binary converter built as an XOR prefix over the
// Gray bits, one reduction per output bit.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer and status controller for the asynchronous FIFO:
// binary/Gray write pointer, registered full/almost-full/level and sticky overflow.
module wr_ptr_full_ctrl
    import wr_ptr_full_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 4,
    parameter int ALMOST_FULL_LEVEL = fifo_depth(ADDRESS_WIDTH) - 2
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst_n,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH:0]   wr_q2_rd_ptr,
    input  logic                     overflow_clr,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic                     wr_push,
    output logic [ADDRESS_WIDTH:0]   wr_ptr,
    output logic                     fifo_full,
    output logic                     fifo_almost_full,
    output logic [ADDRESS_WIDTH:0]   wr_level,
    output logic                     overflow
);

    localparam int PW = ADDRESS_WIDTH + 1;

    logic [PW-1:0] wr_bin_q, wr_bin_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] full_cmp;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;

    gray2bin #(
        .WIDTH (PW)
    ) u_rd_gray2bin (
        .gray (wr_q2_rd_ptr),
        .bin  (rd_bin)
    );

    assign wr_push = wr_en & ~full_q;

    always_comb begin
        wr_bin_d      = wr_bin_q + {{(PW-1){1'b0}}, wr_push};
        wr_ptr_d      = PW'(bin_to_gray(ptr_word_t'(wr_bin_d)));
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_cmp      = {~wr_q2_rd_ptr[ADDRESS_WIDTH -: 2], wr_q2_rd_ptr[ADDRESS_WIDTH-2:0]};
        full_d        = (wr_ptr_d == full_cmp);
        level_d       = wr_bin_d - rd_bin;
        almost_full_d = (int'({1'b0, level_d}) >= ALMOST_FULL_LEVEL);
        overflow_d    = (wr_en & full_q) | (overflow_q & ~overflow_clr);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_q      <= '0;
            wr_ptr_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_bin_q      <= wr_bin_d;
            wr_ptr_q      <= wr_ptr_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_addr          = wr_bin_q[ADDRESS_WIDTH-1:0];
    assign wr_ptr           = wr_ptr_q;
    assign fifo_full        = full_q;
    assign fifo_almost_full = almost_full_q;
    assign wr_level         = level_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Self-checking bench for wr_ptr_full_ctrl: directed scenarios plus random
// traffic, compared every cycle against a count-based occupancy model.
module tb_wr_ptr_full_ctrl;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n;
    logic          wr_en;
    logic [AW:0]   wr_q2_rd_ptr;
    logic          overflow_clr;
    logic [AW-1:0] wr_addr;
    logic          wr_push;
    logic [AW:0]   wr_ptr;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic [AW:0]   wr_level;
    logic          overflow;

    wr_ptr_full_ctrl #(
        .ADDRESS_WIDTH     (AW),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .wr_clk           (wr_clk),
        .wr_rst_n         (wr_rst_n),
        .wr_en            (wr_en),
        .wr_q2_rd_ptr     (wr_q2_rd_ptr),
        .overflow_clr     (overflow_clr),
        .wr_addr          (wr_addr),
        .wr_push          (wr_push),
        .wr_ptr           (wr_ptr),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .wr_level         (wr_level),
        .overflow         (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: total writes accepted (w) and total reads seen via the pointer (r).
    int w = 0;
    int r = 0;
    int m_level = 0;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;
    bit m_ovf  = 1'b0;

    function automatic logic [PW-1:0] gray_of(input int v);
        logic [PW-1:0] b;
        b = PW'(v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_rd(input int nr);
        r = nr;
        wr_q2_rd_ptr = gray_of(nr);
    endtask

    task automatic tick();
        @(posedge wr_clk);
        if (wr_en && m_full) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
        if (wr_en && !m_full) w++;
        m_level = w - r;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AFL);
        #1;
    endtask

    task automatic model_reset();
        w = 0; m_level = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        set_rd(0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  32'(wr_addr), 0);
        check({tag, "_ptr"},   32'(wr_ptr), 0);
        check({tag, "_full"},  32'(fifo_full), 0);
        check({tag, "_af"},    32'(fifo_almost_full), 0);
        check({tag, "_level"}, 32'(wr_level), 0);
        check({tag, "_ovf"},   32'(overflow), 0);
    endtask

    always @(negedge wr_clk) begin
        if (chk_en) begin
            cyc++;
            check("wr_addr", 32'(wr_addr), 32'(w % DEPTH));
            check("wr_ptr", 32'(wr_ptr), 32'(gray_of(w)));
            check("fifo_full", 32'(fifo_full), 32'(m_full));
            check("almost_full", 32'(fifo_almost_full), 32'(m_af));
            check("wr_level", 32'(wr_level), 32'(m_level));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("wr_push", 32'(wr_push), 32'(wr_en && !m_full));
            $display("cyc %0d en %0b clr %0b rd %0d addr %0d ptr %b lvl %0d full %0b af %0b ovf %0b",
                     cyc, wr_en, overflow_clr, r, wr_addr, wr_ptr, wr_level,
                     fifo_full, fifo_almost_full, overflow);
        end
    end

    initial begin
        int seen_top;
        int seen_zero;
        int full_cnt;
        int adv;

        wr_rst_n = 1'b1;
        wr_en = 1'b0;
        overflow_clr = 1'b0;
        set_rd(0);

        // Asynchronous reset asserted mid-cycle.
        #3 wr_rst_n = 1'b0;
        #1 check_zero("rst");
        #18 wr_rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        tick();
        tick();
        check("post_rst_full", 32'(fifo_full), 0);
        check("post_rst_level", 32'(wr_level), 0);

        // Fill with the read pointer held at 0.
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (i == 12) check("af_after_13", 32'(fifo_almost_full), 0);
            if (i == 13) check("af_after_14", 32'(fifo_almost_full), 1);
            if (i == 14) check("full_after_15", 32'(fifo_full), 0);
        end
        check("fill_ptr", 32'(wr_ptr), 32'(5'b11000));
        check("fill_full", 32'(fifo_full), 1);
        check("fill_level", 32'(wr_level), 16);
        check("model_fill_level", 32'(m_level), 16);

        // Writes while full are dropped and flagged.
        repeat (3) tick();
        check("ovf_set", 32'(overflow), 1);
        check("ovf_ptr_hold", 32'(wr_ptr), 32'(5'b11000));
        check("ovf_push", 32'(wr_push), 0);
        overflow_clr = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 1);
        wr_en = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 0);
        overflow_clr = 1'b0;

        // One read frees a slot.
        set_rd(1);
        tick();
        check("drain_full", 32'(fifo_full), 0);
        check("drain_level", 32'(wr_level), 15);
        check("drain_addr", 32'(wr_addr), 0);
        wr_en = 1'b1;
        #1 check("drain_push", 32'(wr_push), 1);
        tick();
        check("drain_addr_after", 32'(wr_addr), 1);
        check("drain_ptr_after", 32'(wr_ptr), 32'(5'b11001));
        wr_en = 1'b0;

        // Wrap with the reader tracking two writes behind.
        set_rd(w - 2);
        tick();
        wr_en = 1'b1;
        seen_top = 0; seen_zero = 0; full_cnt = 0;
        repeat (40) begin
            set_rd(w - 1);
            tick();
            if (wr_ptr == 5'b10000) seen_top++;
            if (wr_ptr == 5'b00000) seen_zero++;
            if (fifo_full) full_cnt++;
            check("wrap_level", 32'(wr_level), 2);
        end
        check("wrap_saw_10000", 32'(seen_top > 0), 1);
        check("wrap_saw_zero", 32'(seen_zero > 0), 1);
        check("wrap_never_full", 32'(full_cnt), 0);
        wr_en = 1'b0;

        // Write and read pointer advance in the same cycle at level 15.
        set_rd(w - 15);
        tick();
        check("simul_pre_level", 32'(wr_level), 15);
        wr_en = 1'b1;
        set_rd(r + 1);
        tick();
        check("simul_level", 32'(wr_level), 15);
        check("simul_full", 32'(fifo_full), 0);
        wr_en = 1'b0;

        // Random traffic.
        repeat (1500) begin
            wr_en = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 7) == 0);
            adv = int'($urandom_range(0, 2));
            if (r + adv > w) adv = w - r;
            set_rd(r + adv);
            tick();
        end
        wr_en = 1'b0;
        overflow_clr = 1'b0;

        // Reset in the middle of operation.
        @(negedge wr_clk);
        chk_en = 1'b0;
        #2 wr_rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        @(posedge wr_clk);
        #2 wr_rst_n = 1'b1;
        chk_en = 1'b1;
        check("midrst_addr", 32'(wr_addr), 0);
        wr_en = 1'b1;
        tick();
        check("midrst_first_addr", 32'(wr_addr), 1);
        check("midrst_first_ptr", 32'(wr_ptr), 1);
        wr_en = 1'b0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
